// File: rtl/bus_slave_resp_mux_pkg.sv
// rtl/bus_slave_resp_mux_pkg.sv - shared types and defaults for the registered slave response mux
package bus_slave_resp_mux_pkg;

  localparam int          WORD_DATA_W  = 32;
  localparam int          BUS_TIMEOUT  = 255;
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  // Chip selects, readies and the error qualifier are all active-low on this bus.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    BUS_MUX_IDLE  = 2'd0,
    BUS_MUX_WAIT  = 2'd1,
    BUS_MUX_BLOCK = 2'd2
  } bus_mux_state_e;

  // A disabled watchdog still needs a one-bit counter to keep the declarations legal.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_slave_resp_mux_if.sv
// rtl/bus_slave_resp_mux_if.sv - slave-side and master-side signal bundle of the response mux
interface bus_slave_resp_mux_if
  import bus_slave_resp_mux_pkg::*;
#(
  parameter int SLAVE_NUM = 8,
  parameter int DATA_W    = WORD_DATA_W,
  parameter int SEL_W     = $clog2(SLAVE_NUM)
);

  logic [SLAVE_NUM-1:0]        s_cs_;
  logic [SLAVE_NUM*DATA_W-1:0] s_rd_data;
  logic [SLAVE_NUM-1:0]        s_rdy_;
  logic                        clr_err;
  logic [DATA_W-1:0]           m_rd_data;
  logic                        m_rdy_;
  logic                        m_err_;
  logic                        to_flag;
  logic [SEL_W-1:0]            to_slv;
  logic                        multi_cs_flag;

  modport slave (
    input  s_cs_, s_rd_data, s_rdy_, clr_err,
    output m_rd_data, m_rdy_, m_err_, to_flag, to_slv, multi_cs_flag
  );

  modport master (
    output s_cs_, s_rd_data, s_rdy_, clr_err,
    input  m_rd_data, m_rdy_, m_err_, to_flag, to_slv, multi_cs_flag
  );

endinterface

// File: rtl/bus_slave_prio_enc.sv
// rtl/bus_slave_prio_enc.sv - lowest-index-wins encoder over active-low chip selects
module bus_slave_prio_enc
  import bus_slave_resp_mux_pkg::*;
#(
  parameter int SLAVE_NUM = 8,
  parameter int SEL_W     = $clog2(SLAVE_NUM)
) (
  input  logic [SLAVE_NUM-1:0] s_cs_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 sel_vld_o,
  output logic                 multi_o
);

  // Scan from the top so the lowest active index is the last one written.
  always_comb begin
    sel_o     = '0;
    sel_vld_o = 1'b0;
    multi_o   = 1'b0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (s_cs_i[i] == ENABLE_) begin
        if (sel_vld_o) begin
          multi_o = 1'b1;
        end
        sel_vld_o = 1'b1;
        sel_o     = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_slave_resp_mux.sv
// rtl/bus_slave_resp_mux.sv - registered N-slave response mux with bus-timeout watchdog and sticky status
module bus_slave_resp_mux
  import bus_slave_resp_mux_pkg::*;
#(
  parameter int                SLAVE_NUM = 8,
  parameter int                DATA_W    = WORD_DATA_W,
  parameter int                TIMEOUT   = BUS_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(BUS_ERR_DATA),
  parameter int                SEL_W     = $clog2(SLAVE_NUM)
) (
  input logic                 clk,
  input logic                 reset_,
  bus_slave_resp_mux_if.slave bus
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 1) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [SEL_W-1:0]  sel;
  logic              sel_vld;
  logic              multi;
  logic              slv_rdy;
  logic              to_evt;
  logic [DATA_W-1:0] rd_arr [SLAVE_NUM];

  bus_mux_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] m_rd_data_q, m_rd_data_d;
  logic              m_rdy_q, m_rdy_d;
  logic              m_err_q, m_err_d;
  logic              to_flag_q, to_flag_d;
  logic [SEL_W-1:0]  to_slv_q, to_slv_d;
  logic              multi_q, multi_d;

  bus_slave_prio_enc #(
    .SLAVE_NUM (SLAVE_NUM),
    .SEL_W     (SEL_W)
  ) u_prio_enc (
    .s_cs_i    (bus.s_cs_),
    .sel_o     (sel),
    .sel_vld_o (sel_vld),
    .multi_o   (multi)
  );

  for (genvar g = 0; g < SLAVE_NUM; g++) begin : g_unpack
    assign rd_arr[g] = bus.s_rd_data[g*DATA_W +: DATA_W];
  end

  assign slv_rdy = sel_vld && (bus.s_rdy_[sel] == ENABLE_);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    to_evt  = 1'b0;
    unique case (state_q)
      BUS_MUX_IDLE: begin
        if (TIMEOUT != 0 && sel_vld && !slv_rdy) begin
          if (TIMEOUT == 1) begin
            to_evt  = 1'b1;
            state_d = BUS_MUX_BLOCK;
          end else begin
            state_d = BUS_MUX_WAIT;
            cnt_d   = CNT_W'(1);
            sel_d   = sel;
          end
        end
      end
      BUS_MUX_WAIT: begin
        if (!sel_vld || slv_rdy) begin
          state_d = BUS_MUX_IDLE;
          cnt_d   = '0;
        end else if (sel != sel_q) begin
          // A different slave is now addressed: treat it as a fresh transaction.
          cnt_d = CNT_W'(1);
          sel_d = sel;
        end else if (cnt_q == CNT_LAST) begin
          to_evt  = 1'b1;
          state_d = BUS_MUX_BLOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BUS_MUX_BLOCK: begin
        if (!sel_vld) begin
          state_d = BUS_MUX_IDLE;
        end
      end
      default: begin
        state_d = BUS_MUX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    m_rd_data_d = '0;
    m_rdy_d     = DISABLE_;
    m_err_d     = DISABLE_;
    if (state_q != BUS_MUX_BLOCK && slv_rdy) begin
      m_rd_data_d = rd_arr[sel];
      m_rdy_d     = ENABLE_;
    end else if (to_evt) begin
      m_rd_data_d = ERR_DATA;
      m_rdy_d     = ENABLE_;
      m_err_d     = ENABLE_;
    end
  end

  // Set events outrank a simultaneous clear; to_slv only records the first timeout.
  always_comb begin
    to_flag_d = to_evt | (to_flag_q & ~bus.clr_err);
    to_slv_d  = to_slv_q;
    if (to_evt && !(to_flag_q && !bus.clr_err)) begin
      to_slv_d = sel;
    end
    multi_d = multi | (multi_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q     <= BUS_MUX_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      m_rd_data_q <= '0;
      m_rdy_q     <= DISABLE_;
      m_err_q     <= DISABLE_;
      to_flag_q   <= 1'b0;
      to_slv_q    <= '0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      m_rd_data_q <= m_rd_data_d;
      m_rdy_q     <= m_rdy_d;
      m_err_q     <= m_err_d;
      to_flag_q   <= to_flag_d;
      to_slv_q    <= to_slv_d;
      multi_q     <= multi_d;
    end
  end

  assign bus.m_rd_data     = m_rd_data_q;
  assign bus.m_rdy_        = m_rdy_q;
  assign bus.m_err_        = m_err_q;
  assign bus.to_flag       = to_flag_q;
  assign bus.to_slv        = to_slv_q;
  assign bus.multi_cs_flag = multi_q;

endmodule

// File: tb/tb_bus_slave_resp_mux.sv
// tb/tb_bus_slave_resp_mux.sv - scoreboard bench for bus_slave_resp_mux (TIMEOUT=4 and TIMEOUT=0 instances)
module tb_bus_slave_resp_mux;

  typedef struct packed {
    logic [31:0] d;
    logic        rdy;
    logic        err;
    logic        tof;
    logic [2:0]  slv;
    logic        mcs;
    logic        chk_slv;
    logic [15:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cs_v = 8'hFF;
  logic [7:0]  rdy_v = 8'hFF;
  logic        clr_v = 1'b0;
  logic        hang_win = 1'b0;

  logic        e_to = 1'b0;
  logic [2:0]  e_slv = 3'd0;
  logic        e_mcs = 1'b0;
  logic [15:0] next_id = 16'd0;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   b_err = 0;
  int   b_rdy = 0;

  always #5 clk = ~clk;

  bus_slave_resp_mux_if #(.SLAVE_NUM(8), .DATA_W(32)) ifa ();
  bus_slave_resp_mux_if #(.SLAVE_NUM(8), .DATA_W(32)) ifb ();

  function automatic logic [31:0] sd(input int i);
    return (i == 3) ? 32'h1234_5678 : (32'hA000_0000 + 32'(i));
  endfunction

  function automatic logic [7:0] one_low(input int i);
    logic [7:0] v;
    v    = 8'hFF;
    v[i] = 1'b0;
    return v;
  endfunction

  for (genvar g = 0; g < 8; g++) begin : g_data
    assign ifa.s_rd_data[g*32 +: 32] = sd(g);
  end
  assign ifa.s_cs_     = cs_v;
  assign ifa.s_rdy_    = rdy_v;
  assign ifa.clr_err   = clr_v;
  assign ifb.s_cs_     = cs_v;
  assign ifb.s_rdy_    = rdy_v;
  assign ifb.clr_err   = clr_v;
  assign ifb.s_rd_data = ifa.s_rd_data;

  bus_slave_resp_mux #(.SLAVE_NUM(8), .DATA_W(32), .TIMEOUT(4)) dut_a (
    .clk    (clk),
    .reset_ (rst_n),
    .bus    (ifa)
  );

  bus_slave_resp_mux #(.SLAVE_NUM(8), .DATA_W(32), .TIMEOUT(0)) dut_b (
    .clk    (clk),
    .reset_ (rst_n),
    .bus    (ifb)
  );

  // Apply one cycle of inputs, then queue what the registered outputs must show after that edge.
  task automatic step(input logic [7:0] cs, input logic [7:0] rdy, input logic clr,
                      input logic [31:0] ed, input logic erdy, input logic eerr);
    logic chk;
    chk   = e_to || !rst_n;
    cs_v  = cs;
    rdy_v = rdy;
    clr_v = clr;
    @(posedge clk);
    #1;
    q.push_back('{ed, erdy, eerr, e_to, e_slv, e_mcs, chk, next_id});
    next_id = next_id + 16'd1;
  endtask

  task automatic idle(input int n, input logic clr);
    for (int k = 0; k < n; k++) step(8'hFF, 8'hFF, clr, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic hung(input int s, input int n);
    for (int k = 0; k < n; k++) step(one_low(s), 8'hFF, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic hung_err(input int s);
    e_to  = 1'b1;
    e_slv = 3'(s);
    step(one_low(s), 8'hFF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (ifa.m_rd_data !== e.d || ifa.m_rdy_ !== e.rdy || ifa.m_err_ !== e.err ||
          ifa.to_flag !== e.tof || ifa.multi_cs_flag !== e.mcs ||
          (e.chk_slv && ifa.to_slv !== e.slv)) begin
        bad++;
        $display("FAIL out%0d: got d=%h rdy_=%b err_=%b to=%b slv=%0d mcs=%b, want d=%h rdy_=%b err_=%b to=%b slv=%0d mcs=%b",
                 e.id, ifa.m_rd_data, ifa.m_rdy_, ifa.m_err_, ifa.to_flag, ifa.to_slv, ifa.multi_cs_flag,
                 e.d, e.rdy, e.err, e.tof, e.slv, e.mcs);
      end
    end
    if (rst_n && ifb.m_rdy_ === 1'b0 && ifb.m_err_ !== 1'b1) b_err++;
    if (hang_win && ifb.m_rdy_ !== 1'b1) b_rdy++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    idle(2, 1'b0);
    rst_n = 1'b1;
    idle(1, 1'b0);

    // Single slave ready immediately: one-cycle latency, one-cycle pulse
    step(one_low(3), one_low(3), 1'b0, 32'h1234_5678, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Two selects: lowest index wins, sticky flag survives a clear in a set cycle
    e_mcs = 1'b1;
    step(8'hDB, 8'hDB, 1'b0, sd(2), 1'b0, 1'b1);
    idle(1, 1'b0);
    step(8'hDB, 8'hDB, 1'b1, sd(2), 1'b0, 1'b1);
    e_mcs = 1'b0;
    idle(1, 1'b1);

    // Hung slave 6: error in cycle 4 only, blocked while held, served after release
    hung(6, 3);
    hung_err(6);
    hung(6, 4);
    idle(1, 1'b0);
    step(one_low(6), one_low(6), 1'b0, sd(6), 1'b0, 1'b1);
    idle(1, 1'b0);
    e_to = 1'b0;
    idle(1, 1'b1);

    // Ready arrives exactly at the count limit: normal response wins
    hung(4, 3);
    step(one_low(4), one_low(4), 1'b0, sd(4), 1'b0, 1'b1);
    idle(1, 1'b0);

    // Select moves from slave 1 to slave 0 with count 2: counter restarts
    hung(1, 2);
    hung(0, 3);
    hung_err(0);
    idle(1, 1'b0);
    e_to = 1'b0;
    idle(1, 1'b1);

    // Select released in WAIT: no error
    hung(2, 2);
    idle(5, 1'b0);

    // Reset during WAIT clears everything, then a fresh transaction times out
    hung(7, 3);
    hung_err(7);
    idle(1, 1'b0);
    hung(5, 2);
    rst_n = 1'b0;
    e_to  = 1'b0;
    e_slv = 3'd0;
    hung(5, 1);
    rst_n = 1'b1;
    hung(5, 3);
    hung_err(5);
    idle(1, 1'b0);
    e_to = 1'b0;
    idle(1, 1'b1);

    // Long hang: TIMEOUT=4 instance errors once, TIMEOUT=0 instance never responds
    hang_win = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (k == 3) hung_err(1);
      else hung(1, 1);
    end
    hang_win = 1'b0;
    idle(2, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    total++;
    if (b_err != 0) begin
      bad++;
      $display("FAIL t0_err: got %0d error responses, want 0", b_err);
    end
    total++;
    if (b_rdy != 0) begin
      bad++;
      $display("FAIL t0_hang_rdy: got %0d ready cycles, want 0", b_rdy);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
